// File: rtl/cbd_sampler.sv
// Centered-binomial sampler: buffers one 32-bit random word and streams K = 32/(2*ETA)
// coefficients reduced into [0, Q-1], tagging the last coefficient of every N-coefficient polynomial.
module cbd_sampler #(
    parameter int ETA     = 2,
    parameter int Q       = 17,
    parameter int N       = 4,
    parameter int COEFF_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COEFF_W-1:0] out_coeff,
    output logic               out_last,
    output logic               busy
);

    localparam int K      = 32 / (2 * ETA);
    localparam int IDX_W  = $clog2(K);
    localparam int POLY_W = (N > 1) ? $clog2(N) : 1;

    if (ETA != 1 && ETA != 2) begin : g_bad_eta
        $error("cbd_sampler: ETA must be 1 or 2");
    end
    if (Q <= 2 * ETA) begin : g_bad_q
        $error("cbd_sampler: Q must exceed 2*ETA");
    end
    if (K % N != 0) begin : g_bad_n
        $error("cbd_sampler: N must divide 32/(2*ETA)");
    end
    if ((1 << COEFF_W) < Q) begin : g_bad_w
        $error("cbd_sampler: COEFF_W too narrow for Q");
    end

    typedef enum logic {IDLE, EMIT} state_t;

    state_t              state_q, state_d;
    logic [31:0]         word_q, word_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [POLY_W-1:0]   poly_q, poly_d;
    logic [COEFF_W-1:0]  coeff_q, coeff_d;

    logic take_out;
    logic last_idx;
    logic load;

    // a - b for one 2*ETA-bit group, folded into [0, Q-1] by adding Q when negative
    function automatic logic [COEFF_W-1:0] cbd_coeff(input logic [31:0] w, input logic [IDX_W-1:0] idx);
        logic [31:0]      sh;
        logic [COEFF_W:0] a;
        logic [COEFF_W:0] b;
        sh = w >> (32'(idx) * 32'(2 * ETA));
        a  = '0;
        b  = '0;
        for (int j = 0; j < ETA; j++) begin
            a = a + (COEFF_W + 1)'(sh[j]);
            b = b + (COEFF_W + 1)'(sh[j + ETA]);
        end
        if (a >= b) return COEFF_W'(a - b);
        return COEFF_W'((COEFF_W + 1)'(Q) + a - b);
    endfunction

    assign take_out = (state_q == EMIT) && out_ready;
    assign last_idx = (idx_q == IDX_W'(K - 1));
    assign in_ready = !clear && ((state_q == IDLE) || (state_q == EMIT && last_idx && out_ready));
    assign load     = in_ready && in_valid;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        poly_d  = poly_q;
        coeff_d = coeff_q;
        if (clear) begin
            state_d = IDLE;
            word_d  = '0;
            idx_d   = '0;
            poly_d  = '0;
            coeff_d = '0;
        end else begin
            if (take_out) begin
                poly_d  = (poly_q == POLY_W'(N - 1)) ? '0 : poly_q + 1'b1;
                idx_d   = idx_q + 1'b1;
                coeff_d = cbd_coeff(word_q, idx_q + 1'b1);
            end
            if (load) begin
                state_d = EMIT;
                word_d  = in_data;
                idx_d   = '0;
                coeff_d = cbd_coeff(in_data, '0);
            end else if (take_out && last_idx) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            poly_q  <= '0;
            coeff_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            poly_q  <= poly_d;
            coeff_q <= coeff_d;
        end
    end

    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign out_coeff = coeff_q;
    assign out_last  = out_valid && (poly_q == POLY_W'(N - 1));

endmodule

// File: tb/tb_cbd_sampler.sv
// Scoreboard bench for cbd_sampler (ETA=2, Q=17, N=4): expected coefficients are queued
// when a word is offered and compared as each coefficient handshakes.
module tb_cbd_sampler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_coeff;
    logic        out_last;
    logic        busy;

    always #5 clk = ~clk;

    cbd_sampler #(.ETA(2), .Q(17), .N(4), .COEFF_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coeff (out_coeff),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct {
        logic [4:0] c;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   exp_poly = 0;

    function automatic logic [4:0] ref_coeff(input logic [31:0] w, input int i);
        int a;
        int b;
        a = int'(w[4*i]) + int'(w[4*i+1]);
        b = int'(w[4*i+2]) + int'(w[4*i+3]);
        return (a >= b) ? 5'(a - b) : 5'(17 + a - b);
    endfunction

    task automatic push_exp(input logic [4:0] c);
        exp_t e;
        e.c = c;
        e.l = (exp_poly == 3);
        sb.push_back(e);
        exp_poly = (exp_poly + 1) % 4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_coeff !== 5'd0) begin errors++; $display("FAIL reset_out_coeff got=%0d want=0", out_coeff); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b want=0", out_valid); end
        tick();
    endtask

    task automatic test_single_word(input logic [31:0] w, input logic [4:0] tab [8]);
        exp_t e;
        for (int i = 0; i < 8; i++) push_exp(tab[i]);
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL word_accept_ready w=%h got=%b want=1", w, in_ready); end
        tick();
        in_valid = 1'b0; in_data = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("FAIL word_valid w=%h k=%0d got=%b/%b want=1/1", w, k, out_valid, busy);
            end else begin
                e = sb.pop_front();
                checks++;
                if (out_coeff !== e.c || out_last !== e.l) begin
                    errors++; $display("FAIL word_coeff w=%h k=%0d got=%0d/%b want=%0d/%b", w, k, out_coeff, out_last, e.c, e.l);
                end
            end
            tick();
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL word_done w=%h busy=%b valid=%b want=0/0", w, busy, out_valid); end
        sb.delete();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1, w2;
        exp_t e;
        w1 = $urandom; w2 = $urandom;
        for (int i = 0; i < 8; i++) push_exp(ref_coeff(w1, i));
        for (int i = 0; i < 8; i++) push_exp(ref_coeff(w2, i));
        in_valid = 1'b1; in_data = w1; out_ready = 1'b1;
        tick();
        in_data = w2;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_valid k=%0d got=%b want=1", k, out_valid);
            end else begin
                e = sb.pop_front();
                checks++;
                if (out_coeff !== e.c || out_last !== e.l) begin
                    errors++; $display("FAIL b2b_coeff k=%0d got=%0d/%b want=%0d/%b", k, out_coeff, out_last, e.c, e.l);
                end
            end
            if (k < 8) begin
                checks++;
                if (in_ready !== (k == 7)) begin errors++; $display("FAIL b2b_in_ready k=%0d got=%b want=%b", k, in_ready, (k == 7)); end
            end
            tick();
            if (k == 7) in_valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done got=%b want=0", out_valid); end
        sb.delete();
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        exp_t e;
        int got;
        w = $urandom;
        for (int i = 0; i < 8; i++) push_exp(ref_coeff(w, i));
        in_valid = 1'b1; in_data = w; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_valid cyc=%0d got=%b want=1", cyc, out_valid);
            end else if (out_ready) begin
                e = sb.pop_front();
                checks++;
                if (out_coeff !== e.c || out_last !== e.l) begin
                    errors++; $display("FAIL bp_coeff n=%0d got=%0d/%b want=%0d/%b", got, out_coeff, out_last, e.c, e.l);
                end
                checks++;
                if (in_ready !== (got == 7)) begin errors++; $display("FAIL bp_in_ready n=%0d got=%b want=%b", got, in_ready, (got == 7)); end
                got++;
            end else begin
                checks++;
                if (out_coeff !== sb[0].c || out_last !== sb[0].l || in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_hold cyc=%0d got=%0d/%b rdy=%b want=%0d/%b rdy=0", cyc, out_coeff, out_last, in_ready, sb[0].c, sb[0].l);
                end
            end
            tick();
        end
        checks++; if (got != 8) begin errors++; $display("FAIL bp_timeout got=%0d want=8", got); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_done got=%b want=0", out_valid); end
        sb.delete();
        tick();
    endtask

    task automatic test_abort(input bit use_reset);
        logic [31:0] w, w2;
        logic [4:0]  tab [8];
        exp_t e;
        w = $urandom | 32'h0000_0003;
        for (int i = 0; i < 8; i++) push_exp(ref_coeff(w, i));
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_coeff !== e.c || out_last !== e.l) begin
                errors++; $display("FAIL abort_pre k=%0d got=%b/%0d/%b want=1/%0d/%b", k, out_valid, out_coeff, out_last, e.c, e.l);
            end
            tick();
        end
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0 || out_coeff !== 5'd0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL abort_rst_now got v=%b c=%0d l=%b b=%b r=%b want 0/0/0/0/1", out_valid, out_coeff, out_last, busy, in_ready);
            end
            tick();
            rst_n = 1'b1;
        end else begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
            errors++; $display("FAIL abort_after rst=%0d got v=%b b=%b r=%b l=%b want 0/0/1/0", use_reset, out_valid, busy, in_ready, out_last);
        end
        sb.delete();
        exp_poly = 0;
        tick();
        w2 = $urandom;
        for (int i = 0; i < 8; i++) tab[i] = ref_coeff(w2, i);
        test_single_word(w2, tab);
    endtask

    initial begin
        logic [4:0] tab [8];
        logic [31:0] w;
        test_reset();
        tab = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        test_single_word(32'h0000_0000, tab);
        tab = '{5'd2, 5'd15, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        test_single_word(32'h0000_00C3, tab);
        tab = '{5'd0, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        test_single_word(32'h0000_004F, tab);
        for (int r = 0; r < 3; r++) begin
            w = $urandom;
            for (int i = 0; i < 8; i++) tab[i] = ref_coeff(w, i);
            test_single_word(w, tab);
        end
        test_back_to_back();
        test_backpressure();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
